// File: rtl/bus_enc_pkg.sv
// bus_enc_pkg: shared constants and helpers for the bus grant encoder
package bus_enc_pkg;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR = 1;
    localparam int ERR_CNT_W = 8;
    function automatic int ENC_NONE(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/bus_grant_encoder_if.sv
// bus_grant_encoder_if: request/result handshake bundle of the grant encoder
interface bus_grant_encoder_if #(parameter int N = 32) ();
    localparam int W = $clog2(N);
    logic [N-1:0] req;
    logic req_valid;
    logic req_ready;
    logic [W-1:0] enc_out;
    logic out_valid;
    logic out_ready;
    logic none;
    logic multi_hot;
    logic [7:0] err_count;
    modport slave (
        input req, req_valid, out_ready,
        output req_ready, enc_out, out_valid, none, multi_hot, err_count
    );
    modport master (
        output req, req_valid, out_ready,
        input req_ready, enc_out, out_valid, none, multi_hot, err_count
    );
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: lowest-set-bit search starting at ptr, wrapping through a doubled request vector
module rr_priority_pick import bus_enc_pkg::*; #(
    parameter int N = 32,
    parameter int MODE = MODE_FIXED,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic any,
    output logic multi
);
    logic [W-1:0] start;
    logic [2*N-1:0] masked;
    assign start = (MODE == MODE_RR) ? ptr : '0;
    assign any = |req;
    assign multi = |(req & (req - 1'b1));
    // lower copy masked below start; upper copy supplies the wrapped candidates
    always_comb begin
        masked = {req, req};
        for (int i = 0; i < N; i++)
            if (i < int'(start)) masked[i] = 1'b0;
        winner = W'(ENC_NONE(W));
        for (int i = 2 * N - 1; i >= 0; i--)
            if (masked[i]) winner = W'(i >= N ? i - N : i);
    end
endmodule

// File: rtl/bus_grant_encoder.sv
// bus_grant_encoder: registered fixed-priority / round-robin request encoder with valid/ready output
module bus_grant_encoder import bus_enc_pkg::*; #(
    parameter int N = 32,
    parameter int MODE = MODE_FIXED,
    localparam int W = $clog2(N)
) (
    input logic clock,
    input logic clear,
    bus_grant_encoder_if.slave bus
);
    logic [W-1:0] ptr, winner, enc_q;
    logic any, multi, load, valid_q, none_q, multi_q;
    logic [ERR_CNT_W-1:0] err_q;
    rr_priority_pick #(.N(N), .MODE(MODE)) u_pick (
        .req(bus.req),
        .ptr(ptr),
        .winner(winner),
        .any(any),
        .multi(multi)
    );
    assign bus.req_ready = !valid_q || bus.out_ready;
    assign load = bus.req_valid && bus.req_ready;
    assign bus.enc_out = enc_q;
    assign bus.out_valid = valid_q;
    assign bus.none = none_q;
    assign bus.multi_hot = multi_q;
    assign bus.err_count = err_q;
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            enc_q <= W'(ENC_NONE(W));
            valid_q <= 1'b0;
            none_q <= 1'b0;
            multi_q <= 1'b0;
            err_q <= '0;
            ptr <= '0;
        end else begin
            if (load) begin
                enc_q <= winner;
                none_q <= !any;
                multi_q <= multi;
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (load && any && MODE == MODE_RR)
                ptr <= (winner == W'(N - 1)) ? '0 : winner + 1'b1;
            if (load && (!any || multi) && err_q != '1)
                err_q <= err_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_grant_encoder.sv
// tb_bus_grant_encoder: directed + random checks of three encoder configurations against a search model
module tb_bus_grant_encoder;
    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;
    logic [31:0] t_req[3];
    logic t_rv[3], t_ordy[3];
    int o_enc[3], o_err[3];
    logic o_val[3], o_none[3], o_multi[3], o_rdy[3];
    int total = 0;
    int bad = 0;
    bus_grant_encoder_if #(.N(32)) ifa ();
    bus_grant_encoder_if #(.N(8)) ifb ();
    bus_grant_encoder_if #(.N(6)) ifc ();
    bus_grant_encoder #(.N(32), .MODE(0)) dut_a (.clock(clk), .clear(clear), .bus(ifa));
    bus_grant_encoder #(.N(8), .MODE(1)) dut_b (.clock(clk), .clear(clear), .bus(ifb));
    bus_grant_encoder #(.N(6), .MODE(1)) dut_c (.clock(clk), .clear(clear), .bus(ifc));
    assign ifa.req = t_req[0];
    assign ifb.req = t_req[1][7:0];
    assign ifc.req = t_req[2][5:0];
    assign ifa.req_valid = t_rv[0];
    assign ifb.req_valid = t_rv[1];
    assign ifc.req_valid = t_rv[2];
    assign ifa.out_ready = t_ordy[0];
    assign ifb.out_ready = t_ordy[1];
    assign ifc.out_ready = t_ordy[2];
    assign o_enc[0] = int'(ifa.enc_out);
    assign o_enc[1] = int'(ifb.enc_out);
    assign o_enc[2] = int'(ifc.enc_out);
    assign o_err[0] = int'(ifa.err_count);
    assign o_err[1] = int'(ifb.err_count);
    assign o_err[2] = int'(ifc.err_count);
    assign o_val[0] = ifa.out_valid;
    assign o_val[1] = ifb.out_valid;
    assign o_val[2] = ifc.out_valid;
    assign o_none[0] = ifa.none;
    assign o_none[1] = ifb.none;
    assign o_none[2] = ifc.none;
    assign o_multi[0] = ifa.multi_hot;
    assign o_multi[1] = ifb.multi_hot;
    assign o_multi[2] = ifc.multi_hot;
    assign o_rdy[0] = ifa.req_ready;
    assign o_rdy[1] = ifb.req_ready;
    assign o_rdy[2] = ifc.req_ready;

    function automatic int nof(input int d);
        return d == 0 ? 32 : (d == 1 ? 8 : 6);
    endfunction
    function automatic int mof(input int d);
        return d == 0 ? 0 : 1;
    endfunction
    function automatic int nonev(input int d);
        return (1 << $clog2(nof(d))) - 1;
    endfunction
    function automatic logic [31:0] maskof(input int d);
        return d == 0 ? 32'hFFFF_FFFF : (32'd1 << nof(d)) - 32'd1;
    endfunction
    // walk positions in search order; -1 means nothing requested
    function automatic int pick(input logic [31:0] r, input int n, input int mode, input int p);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (mode == 1 ? p + k : k) % n;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    logic m_val[3], m_none[3], m_multi[3];
    int m_enc[3], m_err[3], m_ptr[3];
    always @(posedge clk or negedge clear) begin
        for (int d = 0; d < 3; d++) begin
            if (!clear) begin
                m_val[d] <= 1'b0;
                m_none[d] <= 1'b0;
                m_multi[d] <= 1'b0;
                m_enc[d] <= nonev(d);
                m_err[d] <= 0;
                m_ptr[d] <= 0;
            end else if (t_rv[d] && (!m_val[d] || t_ordy[d])) begin
                m_val[d] <= 1'b1;
                m_enc[d] <= pick(t_req[d], nof(d), mof(d), m_ptr[d]) < 0 ? nonev(d) : pick(t_req[d], nof(d), mof(d), m_ptr[d]);
                m_none[d] <= t_req[d] == 0;
                m_multi[d] <= $countones(t_req[d]) > 1;
                if (t_req[d] != 0) m_ptr[d] <= (pick(t_req[d], nof(d), mof(d), m_ptr[d]) + 1) % nof(d);
                if ((t_req[d] == 0 || $countones(t_req[d]) > 1) && m_err[d] < 255) m_err[d] <= m_err[d] + 1;
            end else if (t_ordy[d]) begin
                m_val[d] <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d want %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk("out_valid", d, int'(o_val[d]), int'(m_val[d]));
            chk("enc_out", d, o_enc[d], m_enc[d]);
            chk("none", d, int'(o_none[d]), int'(m_none[d]));
            chk("multi_hot", d, int'(o_multi[d]), int'(m_multi[d]));
            chk("err_count", d, o_err[d], m_err[d]);
            chk("req_ready", d, int'(o_rdy[d]), int'(!m_val[d] || t_ordy[d]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            t_req[d] = '0;
            t_rv[d] = 1'b0;
            t_ordy[d] = 1'b1;
        end
        #1 clear = 1'b0;
        #1;
        chk("rst_enc", 0, o_enc[0], 31);
        chk("rst_valid", 0, int'(o_val[0]), 0);
        chk("rst_err", 0, o_err[0], 0);
        chk("rst_rdy", 0, int'(o_rdy[0]), 1);
        repeat (2) cyc();
        clear = 1'b1;
        // fixed-mode one-hot sweep
        t_rv[0] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            t_req[0] = 32'd1 << k;
            cyc();
            chk("sweep", 0, o_enc[0], k);
        end
        t_rv[0] = 1'b0;
        cyc();
        chk("drain", 0, int'(o_val[0]), 0);
        chk("sweep_err", 0, o_err[0], 0);
        // zero and multi-hot
        t_rv[0] = 1'b1;
        t_req[0] = 32'h0;
        cyc();
        chk("zero_enc", 0, o_enc[0], 31);
        chk("zero_none", 0, int'(o_none[0]), 1);
        t_req[0] = 32'h0000_0A00;
        cyc();
        chk("multi_enc", 0, o_enc[0], 9);
        chk("multi_flag", 0, int'(o_multi[0]), 1);
        t_rv[0] = 1'b0;
        cyc();
        chk("err_two", 0, o_err[0], 2);
        // round-robin wrap, power-of-two and N=6
        t_rv[1] = 1'b1;
        t_req[1] = 32'h81;
        t_rv[2] = 1'b1;
        t_req[2] = 32'h21;
        cyc();
        chk("rr1", 1, o_enc[1], 0);
        chk("rr1", 2, o_enc[2], 0);
        cyc();
        chk("rr2", 1, o_enc[1], 7);
        chk("rr2", 2, o_enc[2], 5);
        cyc();
        chk("rr3", 1, o_enc[1], 0);
        chk("rr3", 2, o_enc[2], 0);
        t_rv[1] = 1'b0;
        t_rv[2] = 1'b0;
        cyc();
        // backpressure
        t_ordy[0] = 1'b0;
        t_rv[0] = 1'b1;
        t_req[0] = 32'h10;
        cyc();
        chk("bp_load", 0, o_enc[0], 4);
        for (int i = 0; i < 3; i++) begin
            t_req[0] = 32'hFF << i;
            cyc();
            chk("bp_hold", 0, o_enc[0], 4);
            chk("bp_rdy", 0, int'(o_rdy[0]), 0);
        end
        t_ordy[0] = 1'b1;
        t_req[0] = 32'h20;
        cyc();
        chk("bp_next", 0, o_enc[0], 5);
        chk("bp_valid", 0, int'(o_val[0]), 1);
        // saturate the error counter, then reset mid-stall
        t_req[0] = 32'h0;
        repeat (260) cyc();
        chk("err_sat", 0, o_err[0], 255);
        t_rv[1] = 1'b1;
        t_req[1] = 32'h04;
        cyc();
        chk("rr_adv", 1, o_enc[1], 2);
        t_ordy[0] = 1'b0;
        t_ordy[1] = 1'b0;
        t_req[0] = 32'h40;
        t_req[1] = 32'h81;
        repeat (2) cyc();
        chk("stall_hold", 1, o_enc[1], 2);
        #2 clear = 1'b0;
        #1;
        chk("clr_enc", 0, o_enc[0], 31);
        chk("clr_valid", 0, int'(o_val[0]), 0);
        chk("clr_none", 0, int'(o_none[0]), 0);
        chk("clr_err", 0, o_err[0], 0);
        chk("clr_rdy", 0, int'(o_rdy[0]), 1);
        chk("clr_enc", 1, o_enc[1], 7);
        cyc();
        clear = 1'b1;
        t_ordy[0] = 1'b1;
        t_ordy[1] = 1'b1;
        cyc();
        chk("post_rst_ptr", 1, o_enc[1], 0);
        chk("post_rst", 0, o_enc[0], 6);
        // random traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 3; d++) begin
                int sel;
                sel = $urandom_range(0, 3);
                t_req[d] = (sel == 0 ? 32'h0 : (sel == 1 ? 32'd1 << $urandom_range(0, nof(d) - 1) : $urandom)) & maskof(d);
                t_rv[d] = $urandom_range(0, 3) != 0;
                t_ordy[d] = $urandom_range(0, 2) != 0;
            end
            cyc();
        end
        for (int d = 0; d < 3; d++) begin
            t_rv[d] = 1'b0;
            t_ordy[d] = 1'b1;
        end
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_grant_encoder.md
# bus_grant_encoder

Parametrised, registered successor to the datapath's one-hot-to-binary select encoder. It converts an N-bit request vector into a W-bit source index for the internal bus multiplexer. It supports fixed-priority and round-robin selection and flags zero-hot and multi-hot inputs. A valid/ready output stage holds the index stable until the bus-select logic accepts it.

## Interface
- `N`, default 32: number of request lines; legal range 2..256.
- `W`, default `$clog2(N)` (derived, not overridden): width of the encoded index.
- `MODE`, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

- `clock`, in, 1: single clock; all state changes on the rising edge.
- `clear`, in, 1: asynchronous, active-low reset.
- `req`, in, N: request vector; may be one-hot, multi-hot or zero.
- `req_valid`, in, 1: `req` is meaningful this cycle.
- `req_ready`, out, 1: block can load a new result; equal to `!out_valid || out_ready`.
- `enc_out`, out, W: registered winning index.
- `out_valid`, out, 1: `enc_out` and the flags are valid.
- `out_ready`, in, 1: downstream accepts the result.
- `none`, out, 1: the loaded `req` was all-zero.
- `multi_hot`, out, 1: the loaded `req` had more than one bit set.
- `err_count`, out, 8: saturating count of loads with `none` or `multi_hot` set.

## Operation
- **Load condition:** `req_valid && req_ready` at a rising edge. On load, the block registers `enc_out`, `none` and `multi_hot`, and sets `out_valid`.
- **Fixed mode (`MODE=0`):** the winner is the lowest set index. One-hot input therefore gives the plain binary encoding (bit k gives k).
- **Round-robin mode (`MODE=1`):**
  - Search starts at pointer `ptr` (W bits, range 0..N-1), ascending, wrapping from N-1 to 0.
  - On a load with at least one bit set, `ptr` becomes winner+1, wrapping to 0 when the winner is N-1. This wrap also applies when N is not a power of two.
  - `ptr` is unchanged on loads where `none` is set.
- **Zero input:** `enc_out` = all ones (`{W{1'b1}}`), `none`=1, `multi_hot`=0. Consumers must qualify `enc_out` with `none`, because all-ones is also a legal index when N = 2^W.
- **Multi-hot input:** the winner is chosen per mode and `multi_hot`=1. This is an error indication only; the result is still delivered.
- **Error counter:** `err_count` increments by 1 on each load with `none || multi_hot`. It saturates at 255 and is cleared only by reset.
- **Output stall:** while `out_valid && !out_ready`, all outputs hold and `req` is ignored.
- **Output drain:** `out_valid` drops the cycle after acceptance unless a new load occurs at the same edge.
- **Back-to-back:** accept and load at the same edge is allowed and sustains one result per cycle.

## Timing
- **Latency:** one cycle from the load edge to `enc_out`/`out_valid`.
- **Throughput:** one result per cycle while `out_ready` is held high.
- **Combinational path:** `req_ready` depends combinationally on `out_ready`. No other input-to-output combinational path exists.
- **Reset values (asynchronous, on `clear`=0):** `enc_out` = all ones, `out_valid`=0, `none`=0, `multi_hot`=0, `err_count`=0, `ptr`=0.
- **Reset mid-operation:** a pending unaccepted result is discarded. The first load after `clear` deasserts uses `ptr`=0.

## Structure
- **Shared package `bus_enc_pkg`:**
  - `ENC_NONE(W)` constant function returning all ones.
  - `MODE_FIXED`/`MODE_RR` localparams.
  - `ERR_CNT_W` = 8.
- **Sub-module `rr_priority_pick`:** combinational; takes `req`, `ptr`, `MODE` and outputs `winner`, `any`, `multi`. The fixed mode is the case `ptr` = 0. It is implemented as a double-width masked lowest-set-bit search.
- **Top level:** the handshake register stage, `ptr` register and error counter live in `bus_grant_encoder`.

## Test plan
- **Fixed-mode one-hot sweep** (N=32, MODE=0): walk a one-hot bit 0..31 with `out_ready`=1. Expect `enc_out` = 0..31 one cycle later, `none`=0, `multi_hot`=0, `err_count`=0.
- **Zero and multi-hot input** (MODE=0):
  - `req`=0: expect `enc_out`=31, `none`=1.
  - `req`=0x00000A00: expect `enc_out`=9, `multi_hot`=1.
  - After both loads: `err_count`=2.
- **Round-robin sequence** (N=8, MODE=1): `req`=0x81 held for 3 loads. Expect 0, 7, 0, with `ptr` wrapping 1 → 0 → 1.
- **Backpressure:** load 0x10, hold `out_ready`=0 for 3 cycles while `req` changes. Expect `enc_out`=4 stable, `req_ready`=0. Then raise `out_ready` with a new `req`=0x20; expect 5 on the next cycle with no bubble.
- **Reset:** assert `clear` mid-stall with `err_count`=255 saturated. Expect all outputs at reset values immediately and `ptr`=0 on the next load.
